uart_transmitter: RTL and testbench

Serial transmit engine for the UART core. It accepts one byte at a time through a valid/ready handshake and serialises it onto `stx_o` as start bit, data bits LSB-first, optional parity, and stop bit(s). Bit timing comes from the shared 16x baud enable `enable_i`. It sits opposite the receive-side input synchroniser and produces frames that the UART receiver accepts.

---
 rtl/uart_transmitter.sv | 176 +++++++++++++++++
 tb/tb_uart_transmitter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// UART transmit engine: holding + shift register feeding a 16x-oversampled framer
// with 5..8 data bits, optional parity, 1/1.5/2 stop bits and a live break override.
module uart_transmitter (
  input  logic       rst_i,
  input  logic       clk_i,
  input  logic       enable_i,
  input  logic [7:0] lcr_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       stx_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic       stop2_q, stop2_d;
  logic       stx_q, stx_d;
  logic [3:0] cfg_q, cfg_d;
  logic       par_q, par_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] hr_q;
  logic       hr_full_q;

  logic       accept;
  logic       load_frame;
  logic [7:0] word_mask;
  logic       par_new;
  logic [2:0] last_bit;
  logic       stop_done;
  logic       unused_lcr;

  assign accept     = tx_valid_i && !hr_full_q;
  assign tx_ready_o = !hr_full_q;
  assign busy_o     = (state_q != S_IDLE);
  assign stx_o      = stx_q & ~lcr_i[6];
  assign unused_lcr = lcr_i[7];

  always_comb begin
    case (lcr_i[1:0])
      2'd0:    word_mask = 8'h1F;
      2'd1:    word_mask = 8'h3F;
      2'd2:    word_mask = 8'h7F;
      default: word_mask = 8'hFF;
    endcase
  end

  // Parity is settled when the frame is loaded, from the same lcr snapshot as the rest of the frame.
  assign par_new  = lcr_i[5] ? ~lcr_i[4] : ((^(hr_q & word_mask)) ^ ~lcr_i[4]);
  assign last_bit = 3'd4 + {1'b0, cfg_q[1:0]};

  // The second stop pass is 8 ticks for 5-bit words (1.5 stop bits), 16 otherwise.
  assign stop_done = !cfg_q[2] ? (tick_q == 4'd15)
                   : !stop2_q  ? 1'b0
                   : (cfg_q[1:0] == 2'd0) ? (tick_q == 4'd7) : (tick_q == 4'd15);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    stop2_d    = stop2_q;
    stx_d      = stx_q;
    sr_d       = sr_q;
    cfg_d      = cfg_q;
    par_d      = par_q;
    load_frame = 1'b0;
    if (enable_i) begin
      tick_d = tick_q + 4'd1;
      case (state_q)
        S_IDLE: begin
          tick_d     = '0;
          load_frame = hr_full_q;
        end
        S_START: begin
          if (tick_q == 4'd15) begin
            state_d = S_DATA;
            bit_d   = '0;
            stx_d   = sr_q[0];
          end
        end
        S_DATA: begin
          if (tick_q == 4'd15) begin
            if (bit_q == last_bit) begin
              if (cfg_q[3]) begin
                state_d = S_PARITY;
                stx_d   = par_q;
              end else begin
                state_d = S_STOP;
                stx_d   = 1'b1;
                stop2_d = 1'b0;
              end
            end else begin
              bit_d = bit_q + 3'd1;
              sr_d  = {1'b0, sr_q[7:1]};
              stx_d = sr_q[1];
            end
          end
        end
        S_PARITY: begin
          if (tick_q == 4'd15) begin
            state_d = S_STOP;
            stx_d   = 1'b1;
            stop2_d = 1'b0;
          end
        end
        S_STOP: begin
          if (stop_done) begin
            if (hr_full_q) begin
              load_frame = 1'b1;
            end else begin
              state_d = S_IDLE;
              tick_d  = '0;
            end
          end else if (tick_q == 4'd15) begin
            stop2_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (load_frame) begin
        state_d = S_START;
        tick_d  = '0;
        stx_d   = 1'b0;
        sr_d    = hr_q;
        cfg_d   = lcr_i[3:0];
        par_d   = par_new;
      end
    end
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      stop2_q   <= 1'b0;
      stx_q     <= 1'b1;
      cfg_q     <= '0;
      par_q     <= 1'b0;
      hr_full_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      stop2_q <= stop2_d;
      stx_q   <= stx_d;
      cfg_q   <= cfg_d;
      par_q   <= par_d;
      if (accept) begin
        hr_full_q <= 1'b1;
      end else if (load_frame) begin
        hr_full_q <= 1'b0;
      end
    end
  end

  // NOTE: the data registers are left unreset; hr_full_q and state_q qualify every use of them.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      hr_q <= tx_data_i;
    end
    sr_q <= sr_d;
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: a per-tick frame model feeds a queue that
// one compare process checks against stx_o/busy_o every cycle, plus directed checks.
module tb_uart_transmitter;

  logic       clk_i      = 1'b0;
  logic       rst_i      = 1'b1;
  logic       enable_i   = 1'b1;
  logic [7:0] lcr_i      = 8'h03;
  logic [7:0] tx_data_i  = 8'h00;
  logic       tx_valid_i = 1'b0;
  logic       tx_ready_o;
  logic       stx_o;
  logic       busy_o;

  uart_transmitter dut (
    .rst_i      (rst_i),
    .clk_i      (clk_i),
    .enable_i   (enable_i),
    .lcr_i      (lcr_i),
    .tx_data_i  (tx_data_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .stx_o      (stx_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // One model sample per enable tick: {busy, line level}.
  typedef logic [1:0] smp_t;
  typedef smp_t smp_q_t[$];
  localparam smp_t IDLE_S = 2'b01;

  smp_q_t exp_q;
  smp_t   cur       = IDLE_S;
  int     checks    = 0;
  int     failures  = 0;
  int     en_period = 1;
  int     en_phase  = 0;
  logic   en_seen   = 1'b0;
  int     cyc       = 0;
  int     busy_cnt  = 0;
  int     acc_cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  // Frame as a list of per-tick line levels, straight from the framing rules.
  function automatic smp_q_t build_frame(input logic [7:0] d, input logic [7:0] lcr);
    smp_q_t f;
    int     n;
    int     stop_ticks;
    logic   ones;
    logic   pv;
    n    = 5 + int'(lcr[1:0]);
    ones = 1'b0;
    for (int t = 0; t < 16; t++) f.push_back(2'b10);
    for (int i = 0; i < n; i++) begin
      ones = ones ^ d[i];
      for (int t = 0; t < 16; t++) f.push_back({1'b1, d[i]});
    end
    if (lcr[3]) begin
      if (lcr[5]) pv = !lcr[4];
      else        pv = lcr[4] ? ones : !ones;
      for (int t = 0; t < 16; t++) f.push_back({1'b1, pv});
    end
    if (!lcr[2])     stop_ticks = 16;
    else if (n == 5) stop_ticks = 24;
    else             stop_ticks = 32;
    for (int t = 0; t < stop_ticks; t++) f.push_back(2'b11);
    return f;
  endfunction

  always @(posedge clk_i) begin
    en_seen <= enable_i;
    cyc     <= cyc + 1;
  end

  initial forever begin
    @(negedge clk_i);
    enable_i = (en_phase == 0);
    en_phase = (en_period <= 1) ? 0 : (en_phase + 1) % en_period;
  end

  // The model advances one sample on each edge where enable_i was high.
  initial forever begin
    @(negedge clk_i);
    if (en_seen) cur = (exp_q.size() != 0) ? exp_q.pop_front() : IDLE_S;
    check("stx", stx_o, cur[0] & ~lcr_i[6]);
    check("busy", busy_o, cur[1]);
    if (busy_o) busy_cnt++;
  end

  task automatic offer(input logic [7:0] d, output bit ok);
    int i;
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    ok = 1'b0;
    i  = 0;
    while (!tx_ready_o && i < 1000) begin
      @(negedge clk_i);
      #1;
      i++;
    end
    check("accept_wait", tx_ready_o, 1'b1);
    if (tx_ready_o) begin
      ok = 1'b1;
      @(posedge clk_i);
      #1;
      acc_cyc = cyc;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] lcr, input bit from_idle,
                      input bit drop_valid);
    bit     ok;
    smp_q_t f;
    offer(d, ok);
    if (ok) begin
      if (from_idle && en_seen) exp_q.push_back(IDLE_S);
      f = build_frame(d, lcr);
      foreach (f[k]) exp_q.push_back(f[k]);
    end
    if (drop_valid) tx_valid_i = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 4000) begin
      @(negedge clk_i);
      i++;
    end
    check("drain", exp_q.size(), 0);
    repeat (3) @(negedge clk_i);
    #1;
  endtask

  task automatic pin_model();
    smp_q_t     f;
    logic [6:0] bits;
    f = build_frame(8'h55, 8'h03);
    check("model_len_8n1", f.size(), 160);
    f = build_frame(8'h41, 8'h1A);
    for (int k = 0; k < 7; k++) bits[k] = f[16 + 16 * k][0];
    check("model_7e1_data", bits, 7'b1000001);
    check("model_7e1_par", f[128][0], 1'b0);
    f = build_frame(8'h41, 8'h0A);
    check("model_7o1_par", f[128][0], 1'b1);
    f = build_frame(8'h41, 8'h3A);
    check("model_stick_even_par", f[128][0], 1'b0);
    f = build_frame(8'h1F, 8'h04);
    check("model_len_5bit_1p5stop", f.size(), 120);
    f = build_frame(8'hC3, 8'h07);
    check("model_len_8bit_2stop", f.size(), 176);
  endtask

  initial begin
    #1 rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_stx", stx_o, 1'b1);
    check("rst_ready", tx_ready_o, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    #1 rst_i = 1'b1;
    pin_model();

    lcr_i = 8'h03;
    send(8'h55, 8'h03, 1'b1, 1'b1);
    busy_cnt = 0;
    drain();
    check("busy_len_8n1", busy_cnt, 160);

    lcr_i = 8'h1A;
    send(8'h41, 8'h1A, 1'b1, 1'b1);
    repeat (30) @(negedge clk_i);
    #2 lcr_i = 8'h07;
    drain();

    lcr_i = 8'h0A;
    send(8'h41, 8'h0A, 1'b1, 1'b1);
    drain();
    lcr_i = 8'h3A;
    send(8'h41, 8'h3A, 1'b1, 1'b1);
    drain();
    lcr_i = 8'h04;
    send(8'h1F, 8'h04, 1'b1, 1'b1);
    drain();
    lcr_i = 8'h07;
    send(8'hC3, 8'h07, 1'b1, 1'b1);
    drain();

    lcr_i = 8'h03;
    begin
      int first_acc;
      send(8'hA5, 8'h03, 1'b1, 1'b0);
      first_acc = acc_cyc;
      send(8'h3C, 8'h03, 1'b0, 1'b1);
      check("b2b_accept_gap", acc_cyc - first_acc, 2);
    end
    drain();

    send(8'h55, 8'h03, 1'b1, 1'b1);
    busy_cnt = 0;
    repeat (52) @(negedge clk_i);
    #2 lcr_i = 8'h43;
    #1 check("break_low", stx_o, 1'b0);
    repeat (6) @(negedge clk_i);
    #2 lcr_i = 8'h03;
    #1 check("break_release", stx_o, cur[0]);
    drain();
    check("busy_len_break", busy_cnt, 160);

    send(8'h55, 8'h03, 1'b1, 1'b1);
    repeat (52) @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    check("midrst_stx", stx_o, 1'b1);
    check("midrst_ready", tx_ready_o, 1'b1);
    check("midrst_busy", busy_o, 1'b0);
    exp_q.delete();
    cur = IDLE_S;
    repeat (3) @(negedge clk_i);
    #2 rst_i = 1'b1;
    send(8'h5A, 8'h03, 1'b1, 1'b1);
    busy_cnt = 0;
    drain();
    check("busy_len_after_rst", busy_cnt, 160);

    @(negedge clk_i);
    en_period = 3;
    lcr_i = 8'h0E;
    repeat (4) @(negedge clk_i);
    #1;
    send(8'hB2, 8'h0E, 1'b1, 1'b1);
    drain();
    en_period = 1;
    repeat (4) @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
